// File: rtl/spi_slave_port_if.sv
// CPU register port of spi_slave_port: Avalon-style bus, two-cycle strobe-gated accesses,
// plus the flow-control pins that mirror RRDY/TRDY/EOP.
interface spi_slave_port_if;
    logic        spi_select;
    logic [2:0]  mem_addr;
    logic        read_n;
    logic        write_n;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;
    logic        endofpacket;

    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu, irq, dataavailable, readyfordata, endofpacket
    );
    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu, irq, dataavailable, readyfordata, endofpacket
    );
endinterface

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave (MSB first, 8-bit frames) with CPU register port; all pins oversampled in clk.
// Optional end-of-packet value/detection at address 6 is built when SPI_SLAVE_EOP_EN is defined.
module spi_slave_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic SCLK,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_oe,
    spi_slave_port_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_d, ss_d, sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic rd_strobe, wr_strobe;
    logic tx_wr, st_wr, ctl_wr, eopv_wr, rx_rd;

    logic [2:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte, tx_shift, tx_holding, rx_holding;
    logic        trdy, rrdy, roe, toe, tur, eop, eop_set, trdy_eff;
    logic [6:0]  ctrl;
    logic [15:0] eop_val, status, rd_mux;
    logic        load, rx_step, tx_step, abort, complete;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign MISO_oe   = ~ss_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    // Strobe goes high in the 2nd cycle of an access and drops itself, so it fires once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            rd_strobe <= bus.spi_select & ~bus.read_n & ~rd_strobe;
            wr_strobe <= bus.spi_select & ~bus.write_n & ~wr_strobe;
        end
    end

    assign tx_wr   = wr_strobe && (bus.mem_addr == 3'd1);
    assign st_wr   = wr_strobe && (bus.mem_addr == 3'd2);
    assign ctl_wr  = wr_strobe && (bus.mem_addr == 3'd3);
    assign eopv_wr = wr_strobe && (bus.mem_addr == 3'd6);
    assign rx_rd   = rd_strobe && (bus.mem_addr == 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rx_step = 1'b0;
        tx_step = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (sclk_rise) begin
                    rx_step = 1'b1;
                end else if (sclk_fall) begin
                    // count==0 on a fall only happens right after the 8th bit
                    if (bit_cnt == 3'd0) load    = 1'b1;
                    else                 tx_step = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign complete = rx_step && (bit_cnt == 3'd7);
    assign rx_byte  = {rx_shift, mosi_s};
    // A txdata write sees TRDY as it stands after a same-cycle shift-register load.
    assign trdy_eff = trdy | load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_holding <= '0;
            rx_holding <= '0;
            MISO       <= 1'b0;
            trdy       <= 1'b1;
            rrdy       <= 1'b0;
            roe        <= 1'b0;
            toe        <= 1'b0;
            tur        <= 1'b0;
            ctrl       <= '0;
        end else begin
            if (load)         tx_shift <= trdy ? 8'h00 : tx_holding;
            else if (tx_step) tx_shift <= {tx_shift[6:0], 1'b0};
            if (state_q == ACTIVE) MISO <= tx_shift[7];

            if (tx_wr && trdy_eff) tx_holding <= bus.data_from_cpu[7:0];
            trdy <= (tx_wr && trdy_eff) ? 1'b0 : trdy_eff;

            if (rx_step)  rx_shift   <= rx_byte[6:0];
            if (complete) rx_holding <= rx_byte;
            if (state_q == IDLE || abort || complete) bit_cnt <= '0;
            else if (rx_step)                         bit_cnt <= bit_cnt + 3'd1;

            // Frame events win over CPU clears.
            if (complete)            rrdy <= 1'b1;
            else if (rx_rd || st_wr) rrdy <= 1'b0;
            if (complete && rrdy && !rx_rd) roe <= 1'b1;
            else if (st_wr)                 roe <= 1'b0;
            if (tx_wr && !trdy_eff) toe <= 1'b1;
            else if (st_wr)         toe <= 1'b0;
            if (load && trdy)  tur <= 1'b1;
            else if (st_wr)    tur <= 1'b0;

            if (ctl_wr) ctrl <= bus.data_from_cpu[9:3];
        end
    end

`ifdef SPI_SLAVE_EOP_EN
    assign eop_set = (complete && rx_byte == eop_val[7:0]) ||
                     (tx_wr && bus.data_from_cpu[7:0] == eop_val[7:0]);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eop_val <= '0;
            eop     <= 1'b0;
        end else begin
            if (eopv_wr) eop_val <= bus.data_from_cpu;
            if (eop_set)    eop <= 1'b1;
            else if (st_wr) eop <= 1'b0;
        end
    end
`else
    logic unused_eop;
    assign eop_val    = '0;
    assign eop        = 1'b0;
    assign eop_set    = 1'b0;
    assign unused_eop = ^{eopv_wr, bus.data_from_cpu[15:10]};
`endif

    assign status = {6'b0, eop, roe | toe | tur, rrdy, trdy, tur, toe, roe, 3'b000};

    always_comb begin
        rd_mux = '0;
        case (bus.mem_addr)
            3'd0:    rd_mux = {8'h00, rx_holding};
            3'd2:    rd_mux = status;
            3'd3:    rd_mux = {6'b0, ctrl, 3'b000};
            3'd6:    rd_mux = eop_val;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.data_to_cpu <= '0;
            bus.irq         <= 1'b0;
        end else begin
            bus.data_to_cpu <= rd_mux;
            bus.irq         <= |(status[9:3] & ctrl);
        end
    end

    assign bus.dataavailable = rrdy;
    assign bus.readyfordata  = trdy;
    assign bus.endofpacket   = eop;
endmodule

// File: tb/tb_spi_slave_port.sv
// Randomized bench for spi_slave_port: a byte-level model of the holding/shift registers and
// status flags predicts MISO bytes, rxdata, status and irq for each SPI frame and CPU access.
module tb_spi_slave_port;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
    logic MISO, MISO_oe;
    int   checks = 0, errors = 0;

    spi_slave_port_if bus();

    spi_slave_port #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // Byte-level reference state
    bit        m_trdy = 1'b1, m_rrdy, m_roe, m_toe, m_tur, m_eop;
    bit [7:0]  m_hold, m_rx;
    bit [15:0] m_eopv;
    bit [6:0]  m_ctl;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] m_status();
        return {6'b0, m_eop, m_roe | m_toe | m_tur, m_rrdy, m_trdy, m_tur, m_toe, m_roe, 3'b000};
    endfunction

    task automatic m_reset();
        m_trdy = 1; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_eop = 0;
        m_hold = 0; m_rx = 0; m_eopv = 0; m_ctl = 0;
    endtask

    task automatic m_load(output logic [7:0] b);
        if (!m_trdy) begin b = m_hold; m_trdy = 1; end
        else begin b = 8'h00; m_tur = 1; end
    endtask

    task automatic m_rxdone(input logic [7:0] b);
        if (m_rrdy) m_roe = 1;
        m_rx = b; m_rrdy = 1;
`ifdef SPI_SLAVE_EOP_EN
        if (b == m_eopv[7:0]) m_eop = 1;
`endif
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.spi_select = 1; bus.write_n = 0; bus.mem_addr = a; bus.data_from_cpu = d;
        repeat (2) @(negedge clk);
        bus.spi_select = 0; bus.write_n = 1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.spi_select = 1; bus.read_n = 0; bus.mem_addr = a;
        repeat (2) @(negedge clk);
        d = bus.data_to_cpu;
        bus.spi_select = 0; bus.read_n = 1;
    endtask

    task automatic wr_tx(input logic [7:0] d);
`ifdef SPI_SLAVE_EOP_EN
        if (d == m_eopv[7:0]) m_eop = 1;
`endif
        if (m_trdy) begin m_hold = d; m_trdy = 0; end
        else m_toe = 1;
        cpu_wr(3'd1, {8'h00, d});
    endtask

    task automatic wr_status();
        m_roe = 0; m_toe = 0; m_tur = 0; m_rrdy = 0; m_eop = 0;
        cpu_wr(3'd2, 16'($urandom));
    endtask

    task automatic wr_ctl(input logic [15:0] d);
        m_ctl = d[9:3];
        cpu_wr(3'd3, d);
    endtask

    task automatic rd_rx(output logic [15:0] r);
        cpu_rd(3'd0, r);
        chk("rxdata", r, {8'h00, m_rx});
        m_rrdy = 0;
    endtask

    task automatic chk_status(input string tag, output logic [15:0] r);
        cpu_rd(3'd2, r);
        chk(tag, r, m_status());
        chk("flow_pins", {bus.dataavailable, bus.readyfordata, bus.endofpacket},
            {m_rrdy, m_trdy, m_eop});
    endtask

    task automatic chk_irq();
        logic [15:0] s;
        repeat (2) @(negedge clk);
        s = m_status();
        chk("irq", bus.irq, |(s[9:3] & m_ctl));
    endtask

    // Drives nbits of mosi (MSB first) inside one select; returns what MISO carried.
    task automatic spi_frame(input logic [15:0] mosi, input int nbits, input int hp,
                             output logic [15:0] miso_all);
        logic [7:0] cur, got;
        int k, p;
        miso_all = '0; got = '0;
        SS_n = 0; MOSI = mosi[15];
        m_load(cur);
        repeat (hp) @(negedge clk);
        chk("miso_oe_active", MISO_oe, 1'b1);
        for (int i = 0; i < nbits; i++) begin
            k = i % 8;
            got[7-k] = MISO;
            miso_all[15-i] = MISO;
            SCLK = 1;
            repeat (hp) @(negedge clk);
            if (k == 7) begin
                m_rxdone(mosi[15-(i-7) -: 8]);
                chk("miso_byte", got, cur);
            end
            SCLK = 0;
            if (i + 1 < 16) MOSI = mosi[14-i];
            repeat (hp) @(negedge clk);
            if (k == 7) m_load(cur);
        end
        p = nbits % 8;
        if (p != 0) chk("miso_partial", got >> (8 - p), cur >> (8 - p));
        SS_n = 1;
        repeat (hp) @(negedge clk);
        chk("miso_oe_idle", MISO_oe, 1'b0);
    endtask

    initial begin
        logic [15:0] r, mo;
        int nb;
        bus.spi_select = 0; bus.read_n = 1; bus.write_n = 1;
        bus.mem_addr = '0; bus.data_from_cpu = '0;
        m_reset();

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_pins", {MISO, MISO_oe, bus.irq}, 3'b000);
        chk("rst_rdata", bus.data_to_cpu, 16'h0000);
        reset_n = 1;
        repeat (2) @(negedge clk);
        chk_status("rst_status", r);
        chk("rst_status_const", r, 16'h0040);
        cpu_rd(3'd3, r);
        chk("rst_control", r, 16'h0000);

        // Single exchange
        wr_tx(8'hA5);
        spi_frame({8'h3C, 8'h00}, 8, 50, mo);
        chk("single_miso", mo[15:8], 8'hA5);
        chk_status("single_status", r);
        rd_rx(r);
        chk("single_rx_const", r, 16'h003C);
        chk("single_rrdy_cleared", bus.dataavailable, 1'b0);

        // Overrun across back-to-back bytes in one select
        wr_status();
        spi_frame({8'h11, 8'h22}, 16, 50, mo);
        chk_status("ovr_status", r);
        chk("ovr_roe", r[3], 1'b1);
        wr_ctl(16'h0008);
        chk_irq();
        chk("ovr_irq_const", bus.irq, 1'b1);
        rd_rx(r);
        chk("ovr_rx_const", r, 16'h0022);
        wr_ctl(16'h0000);
        wr_status();

        // Underrun, abort, then a clean frame
        spi_frame({8'h77, 8'h00}, 8, 50, mo);
        chk("udr_miso", mo[15:8], 8'h00);
        chk_status("udr_status", r);
        chk("udr_tur", r[5], 1'b1);
        rd_rx(r);
        spi_frame(16'hFFFF, 5, 50, mo);
        chk("abort_rrdy", bus.dataavailable, 1'b0);
        spi_frame({8'h5A, 8'h00}, 8, 50, mo);
        rd_rx(r);
        chk("after_abort_rx", r, 16'h005A);

        // TOE
        wr_status();
        wr_tx(8'h11);
        wr_tx(8'h22);
        chk_status("toe_status", r);
        chk("toe_const", r, 16'h0110);
        wr_status();
        chk_status("toe_cleared", r);
        chk("toe_cleared_const", r, 16'h0000);

        // Randomized frames and CPU traffic
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 1) == 1) wr_tx(8'($urandom));
            if ($urandom_range(0, 3) == 0) wr_tx(8'($urandom));
            case ($urandom_range(0, 2))
                0:       nb = 8;
                1:       nb = 16;
                default: nb = $urandom_range(1, 7);
            endcase
            spi_frame(16'($urandom), nb, 8, mo);
            if ($urandom_range(0, 1) == 1) rd_rx(r);
            if ($urandom_range(0, 2) == 0) begin
                wr_ctl(16'($urandom));
                chk_irq();
            end
            chk_status("rnd_status", r);
            if ($urandom_range(0, 3) == 0) wr_status();
        end

        // End-of-packet value
        wr_ctl(16'h0000);
        wr_status();
        m_eopv = 16'h000A;
        cpu_wr(3'd6, 16'h000A);
        cpu_rd(3'd6, r);
`ifdef SPI_SLAVE_EOP_EN
        chk("eop_val", r, 16'h000A);
`else
        m_eopv = 16'h0000;
        chk("eop_val_off", r, 16'h0000);
`endif
        spi_frame({8'h0A, 8'h00}, 8, 50, mo);
        chk_status("eop_status", r);
`ifdef SPI_SLAVE_EOP_EN
        chk("eop_pin_const", bus.endofpacket, 1'b1);
`else
        chk("eop_pin_off", bus.endofpacket, 1'b0);
`endif

        // Reset in the middle of a frame
        SS_n = 0; MOSI = 1;
        repeat (20) @(negedge clk);
        SCLK = 1;
        repeat (10) @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("midrst_pins", {MISO, MISO_oe, bus.irq}, 3'b000);
        chk("midrst_rdata", bus.data_to_cpu, 16'h0000);
        SCLK = 0; SS_n = 1;
        repeat (5) @(negedge clk);
        reset_n = 1;
        m_reset();
        repeat (2) @(negedge clk);
        chk_status("midrst_status", r);
        chk("midrst_status_const", r, 16'h0040);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
